// File: rtl/trigger_unit_pkg.sv
// Shared definitions for the trigger unit.
//   DEF_DATA_WIDTH / DEF_COUNT_WIDTH : default widths of probed data and counters
//   trig_state_t                      : FSM state encoding (IDLE / ARMED / FIRED, 2 bits)
//   norm_count()                      : maps an occurrence target of 0 onto 1
package trigger_unit_pkg;

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_COUNT_WIDTH = 16;

   typedef enum logic [1:0] {
      TRIG_IDLE  = 2'd0,
      TRIG_ARMED = 2'd1,
      TRIG_FIRED = 2'd2
   } trig_state_t;

   // A target of zero would never be reached by a counter that starts at
   // zero and increments before comparing, so it is treated as one.
   function automatic logic [DEF_COUNT_WIDTH-1:0] norm_count(
      input logic [DEF_COUNT_WIDTH-1:0] c
   );
      return (c == '0) ? {{(DEF_COUNT_WIDTH-1){1'b0}}, 1'b1} : c;
   endfunction

endpackage

// File: rtl/trigger_match.sv
// Pattern matcher for the trigger unit.
// Holds the latched mask/value/edge configuration and the previous-match
// flag, and produces the per-cycle qualify strobe.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   i_latch           capture i_mask/i_value/i_edge_en this cycle (arm)
//   i_track           FSM is ARMED: follow match into prev_match
//   i_primed          capture buffer filled
//   i_data            probed data
//   i_mask, i_value   compare pattern (only sampled on i_latch)
//   i_edge_en         edge qualifier (only sampled on i_latch)
//   o_qualify         this cycle counts as an occurrence
module trigger_match
   import trigger_unit_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_latch,
   input  logic                  i_track,
   input  logic                  i_primed,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [DATA_WIDTH-1:0] i_mask,
   input  logic [DATA_WIDTH-1:0] i_value,
   input  logic                  i_edge_en,
   output logic                  o_qualify
);

   logic [DATA_WIDTH-1:0] cfg_mask;
   logic [DATA_WIDTH-1:0] cfg_value;
   logic                  cfg_edge;
   logic                  prev_match;
   logic                  match;

   // Compare only against the latched pattern; a zero mask matches always.
   assign match     = (((i_data ^ cfg_value) & cfg_mask) == '0);
   assign o_qualify = match & i_primed & (cfg_edge ? ~prev_match : 1'b1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfg_mask   <= '0;
         cfg_value  <= '0;
         cfg_edge   <= 1'b0;
         prev_match <= 1'b1;
      end else if (i_latch) begin
         cfg_mask   <= i_mask;
         cfg_value  <= i_value;
         cfg_edge   <= i_edge_en;
         // A match already present at arm time must not look like an edge.
         prev_match <= 1'b1;
      end else if (i_track) begin
         // Tracked even while unprimed so the edge history stays current.
         prev_match <= match;
      end
   end

endmodule

// File: rtl/trigger_unit.sv
// Programmable trigger generator feeding the capture core's i_trigger.
// Counts qualifying pattern matches while the capture buffer is primed and
// emits a registered single-cycle pulse once the occurrence target is hit.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   i_arm           pulse: latch config and enter ARMED (restarts if ARMED)
//   i_disarm        pulse: return to IDLE; beats i_arm and a same-cycle match
//   i_primed        capture buffer filled
//   i_data          probed data
//   i_mask/i_value  compare pattern, i_edge_en edge qualifier, i_count target
//   o_trigger       one-cycle pulse, the cycle after the completing match
//   o_armed/o_fired state flags (o_fired sticky until arm/disarm)
//   o_match_count   qualifying matches since arm
//   o_state         current FSM state for observation
module trigger_unit
   import trigger_unit_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_arm,
   input  logic                   i_disarm,
   input  logic                   i_primed,
   input  logic [DATA_WIDTH-1:0]  i_data,
   input  logic [DATA_WIDTH-1:0]  i_mask,
   input  logic [DATA_WIDTH-1:0]  i_value,
   input  logic                   i_edge_en,
   input  logic [COUNT_WIDTH-1:0] i_count,
   output logic                   o_trigger,
   output logic                   o_armed,
   output logic                   o_fired,
   output logic [COUNT_WIDTH-1:0] o_match_count,
   output trig_state_t            o_state
);

   trig_state_t            state;
   logic [COUNT_WIDTH-1:0] cfg_count;
   logic [COUNT_WIDTH-1:0] match_count;
   logic [COUNT_WIDTH-1:0] count_inc;
   logic                   arm_go;
   logic                   qualify;

   assign arm_go    = i_arm & ~i_disarm;
   assign count_inc = match_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   trigger_match #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_match (
      .clk       (clk),
      .reset     (reset),
      .i_latch   (arm_go),
      .i_track   (state == TRIG_ARMED),
      .i_primed  (i_primed),
      .i_data    (i_data),
      .i_mask    (i_mask),
      .i_value   (i_value),
      .i_edge_en (i_edge_en),
      .o_qualify (qualify)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= TRIG_IDLE;
         cfg_count   <= '0;
         match_count <= '0;
         o_trigger   <= 1'b0;
      end else begin
         o_trigger <= 1'b0;
         if (i_disarm) begin
            state       <= TRIG_IDLE;
            match_count <= '0;
         end else if (i_arm) begin
            // Same path from IDLE, FIRED, or a restart while ARMED.
            state       <= TRIG_ARMED;
            match_count <= '0;
            cfg_count   <= COUNT_WIDTH'(norm_count(DEF_COUNT_WIDTH'(i_count)));
         end else begin
            case (state)
               TRIG_ARMED: begin
                  if (qualify) begin
                     match_count <= count_inc;
                     if (count_inc == cfg_count) begin
                        o_trigger <= 1'b1;
                        state     <= TRIG_FIRED;
                     end
                  end
               end
               default: ;  // IDLE and FIRED wait for arm/disarm
            endcase
         end
      end
   end

   assign o_armed       = (state == TRIG_ARMED);
   assign o_fired       = (state == TRIG_FIRED);
   assign o_match_count = match_count;
   assign o_state       = state;

endmodule

// File: tb/tb_trigger_unit.sv
module tb_trigger_unit;
   import trigger_unit_pkg::*;

   localparam int DW = 8;
   localparam int CW = 16;
   localparam int EW = 3 + CW;  // {trigger, armed, fired, count}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic          i_arm = 0, i_disarm = 0, i_primed = 0, i_edge_en = 0;
   logic [DW-1:0] i_data = 0, i_mask = 0, i_value = 0;
   logic [CW-1:0] i_count = 0;
   logic          o_trigger, o_armed, o_fired;
   logic [CW-1:0] o_match_count;
   trig_state_t   o_state;

   trigger_unit #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .i_arm(i_arm), .i_disarm(i_disarm),
      .i_primed(i_primed), .i_data(i_data), .i_mask(i_mask), .i_value(i_value),
      .i_edge_en(i_edge_en), .i_count(i_count), .o_trigger(o_trigger),
      .o_armed(o_armed), .o_fired(o_fired), .o_match_count(o_match_count),
      .o_state(o_state)
   );

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [EW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Behavioural view: "waiting" flag, "done" flag, an integer tally.
   bit          m_waiting, m_done, m_pulse, m_prev;
   int          m_tally, m_target;
   logic [DW-1:0] m_mask, m_value;
   bit          m_edge;

   task automatic model_reset();
      m_waiting = 0; m_done = 0; m_pulse = 0; m_prev = 1;
      m_tally = 0; m_target = 0; m_mask = 0; m_value = 0; m_edge = 0;
   endtask

   task automatic model_step();
      bit hit, counts;
      hit = ((i_data & m_mask) == (m_value & m_mask));
      m_pulse = 0;
      if (i_disarm) begin
         m_waiting = 0; m_done = 0; m_tally = 0;
      end else if (i_arm) begin
         m_waiting = 1; m_done = 0; m_tally = 0; m_prev = 1;
         m_mask = i_mask; m_value = i_value; m_edge = i_edge_en;
         m_target = (i_count == 0) ? 1 : int'(i_count);
      end else if (m_waiting) begin
         counts = hit && i_primed && (!m_edge || !m_prev);
         m_prev = hit;
         if (counts) begin
            m_tally++;
            if (m_tally == m_target) begin
               m_pulse = 1; m_waiting = 0; m_done = 1;
            end
         end
      end
      exp_q.push_back({m_pulse, m_waiting, m_done, CW'(m_tally)});
   endtask

   // ---------------- driver ----------------
   logic          g_primed = 1, g_edge = 0;
   logic [DW-1:0] g_mask = 8'hFF, g_value = 8'hA5;
   logic [CW-1:0] g_cnt = 1;

   task automatic step(input logic arm, input logic disarm, input logic [DW-1:0] data);
      logic [EW-1:0] e;
      @(negedge clk);
      i_arm = arm; i_disarm = disarm; i_data = data; i_primed = g_primed;
      i_mask = g_mask; i_value = g_value; i_edge_en = g_edge; i_count = g_cnt;
      model_step();
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("trigger", 32'(o_trigger), 32'(e[EW-1]));
      check("armed", 32'(o_armed), 32'(e[EW-2]));
      check("fired", 32'(o_fired), 32'(e[EW-3]));
      check("count", 32'(o_match_count), 32'(e[CW-1:0]));
   endtask

   task automatic arm_cfg(input logic [DW-1:0] m, input logic [DW-1:0] v,
                          input logic e, input logic [CW-1:0] c, input logic [DW-1:0] data);
      g_mask = m; g_value = v; g_edge = e; g_cnt = c;
      step(1, 0, data);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_trigger"}, 32'(o_trigger), 0);
      check({tag, "_armed"}, 32'(o_armed), 0);
      check({tag, "_fired"}, 32'(o_fired), 0);
      check({tag, "_count"}, 32'(o_match_count), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk) reset = 1;

      // 1. basic level trigger
      g_primed = 1;
      arm_cfg(8'hFF, 8'hA5, 0, 1, 8'h00);
      step(0, 0, 8'h00);
      step(0, 0, 8'hA5);
      step(0, 0, 8'h00);
      step(0, 0, 8'hA5);

      // 2. occurrence count of 3
      arm_cfg(8'hFF, 8'hA5, 0, 3, 8'h00);
      repeat (5) step(0, 0, 8'hA5);

      // 3. edge qualifier
      arm_cfg(8'hFF, 8'hA5, 1, 1, 8'hA5);
      repeat (4) step(0, 0, 8'hA5);
      step(0, 0, 8'h00);
      step(0, 0, 8'hA5);
      step(0, 0, 8'h00);

      // 4. priming gate
      g_primed = 0;
      arm_cfg(8'hFF, 8'hA5, 0, 1, 8'h00);
      repeat (10) step(0, 0, 8'hA5);
      g_primed = 1;
      step(0, 0, 8'hA5);
      step(0, 0, 8'hA5);

      // 5. priorities and ignored config changes
      arm_cfg(8'hFF, 8'hA5, 0, 2, 8'h00);
      step(1, 1, 8'hA5);
      arm_cfg(8'hFF, 8'hA5, 0, 1, 8'h00);
      step(0, 1, 8'hA5);
      step(0, 0, 8'hA5);
      arm_cfg(8'hFF, 8'hA5, 0, 1, 8'h00);
      g_mask = 8'h00; g_value = 8'h00; g_cnt = 5;
      step(0, 0, 8'h00);
      step(0, 0, 8'h5A);
      step(0, 0, 8'hA5);
      step(0, 0, 8'h00);
      arm_cfg(8'h0F, 8'h05, 0, 2, 8'h00);
      step(1, 0, 8'hF5);  // restart while ARMED
      step(0, 0, 8'h35);
      step(0, 0, 8'h05);

      // 6. async reset between edges, then count 0 behaves as 1
      arm_cfg(8'hFF, 8'hA5, 0, 4, 8'h00);
      step(0, 0, 8'hA5);
      step(0, 0, 8'hA5);
      #2 reset = 0;
      #1 check_reset_outputs("async");
      model_reset();
      @(negedge clk) reset = 1;
      arm_cfg(8'hFF, 8'hA5, 0, 0, 8'h00);
      step(0, 0, 8'hA5);
      step(0, 0, 8'h00);

      // random phase
      for (int i = 0; i < 2000; i++) begin
         logic a, d;
         logic [DW-1:0] dat;
         a = ($urandom_range(0, 15) == 0);
         d = ($urandom_range(0, 39) == 0);
         g_primed = ($urandom_range(0, 9) < 8);
         case ($urandom_range(0, 3))
            0: g_mask = 8'hFF;
            1: g_mask = 8'h0F;
            2: g_mask = 8'h00;
            default: g_mask = 8'($urandom);
         endcase
         g_value = ($urandom_range(0, 1) != 0) ? 8'hA5 : 8'($urandom);
         g_edge  = 1'($urandom_range(0, 1));
         g_cnt   = 16'($urandom_range(0, 4));
         case ($urandom_range(0, 2))
            0: dat = 8'hA5;
            1: dat = 8'h00;
            default: dat = 8'($urandom);
         endcase
         step(a, d, dat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
